// File: rtl/mmc1_cpu_write_filter.sv
// MMC1 CPU-bus front end: synchronizes the asynchronous Famicom CPU bus,
// detects complete M2 cycles and forwards mapper writes as single-clock
// strobes. A mapper write in the cycle right after another mapper write
// (6502 read-modify-write) is dropped rather than forwarded.
module mmc1_cpu_write_filter #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned GLITCH_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cpu_m2_i,
  input  logic       ncpu_romsel_i,
  input  logic       ncpu_rw_i,
  input  logic       cpu_a14_i,
  input  logic       cpu_a13_i,
  input  logic       cpu_d7_i,
  input  logic       cpu_d0_i,
  output logic       wr_stb_o,
  output logic [1:0] wr_reg_o,
  output logic       wr_d0_o,
  output logic       wr_d7_o,
  output logic       wr_drop_o,
  output logic       m2_timeout_o
);

  localparam int unsigned NIN = 7;
  localparam int unsigned GW  = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES) + 1;
  // Bit order {m2, romsel_n, rw_n, a14, a13, d7, d0}; bus-idle levels.
  localparam logic [NIN-1:0] SYNC_RST = 7'b0110000;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_HIGH = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
  logic [NIN-1:0] async_in;
  logic [NIN-1:0] sync_s;
  logic           m2_s, romsel_n_s, rw_n_s, a14_s, a13_s, d7_s, d0_s;
  logic           wr_cond;

  logic           m2_filt_q;
  logic           m2_rise_q;
  logic [GW-1:0]  gcnt_q;

  state_e         state_q;
  logic [TW-1:0]  to_cnt_q;
  logic           cap_wr_q, cap_a14_q, cap_a13_q, cap_d7_q, cap_d0_q;
  logic           prev_wr_q;
  logic           wr_stb_q, wr_drop_q, m2_timeout_q;
  logic [1:0]     wr_reg_q;
  logic           wr_d0_q, wr_d7_q;

  assign async_in = {cpu_m2_i, ncpu_romsel_i, ncpu_rw_i, cpu_a14_i, cpu_a13_i,
                     cpu_d7_i, cpu_d0_i};
  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign {m2_s, romsel_n_s, rw_n_s, a14_s, a13_s, d7_s, d0_s} = sync_s;
  assign wr_cond  = !romsel_n_s && !rw_n_s;

  // Input synchronizer chains, all the same depth so bus signals stay aligned.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{SYNC_RST}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  // M2 deglitch: a new level must persist GLITCH_CYCLES samples to be accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m2_filt_q <= 1'b0;
      m2_rise_q <= 1'b0;
      gcnt_q    <= '0;
    end else begin
      m2_rise_q <= 1'b0;
      if (m2_s != m2_filt_q) begin
        if (gcnt_q == GW'(GLITCH_CYCLES - 1)) begin
          m2_filt_q <= m2_s;
          m2_rise_q <= m2_s;
          gcnt_q    <= '0;
        end else begin
          gcnt_q <= gcnt_q + GW'(1);
        end
      end else begin
        gcnt_q <= '0;
      end
    end
  end

  // Cycle FSM: capture during the high phase, decide strobe/drop after the fall.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_LOW;
      to_cnt_q     <= '0;
      cap_wr_q     <= 1'b0;
      cap_a14_q    <= 1'b0;
      cap_a13_q    <= 1'b0;
      cap_d7_q     <= 1'b0;
      cap_d0_q     <= 1'b0;
      prev_wr_q    <= 1'b0;
      wr_stb_q     <= 1'b0;
      wr_drop_q    <= 1'b0;
      m2_timeout_q <= 1'b0;
      wr_reg_q     <= 2'b00;
      wr_d0_q      <= 1'b0;
      wr_d7_q      <= 1'b0;
    end else begin
      wr_stb_q     <= 1'b0;
      wr_drop_q    <= 1'b0;
      m2_timeout_q <= 1'b0;
      case (state_q)
        ST_LOW: begin
          cap_wr_q <= 1'b0;
          to_cnt_q <= '0;
          if (m2_rise_q) begin
            state_q <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          // Sticky write flag; data follows the last qualifying sample.
          if (m2_s && wr_cond) begin
            cap_wr_q  <= 1'b1;
            cap_a14_q <= a14_s;
            cap_a13_q <= a13_s;
            cap_d7_q  <= d7_s;
            cap_d0_q  <= d0_s;
          end
          if (!m2_filt_q) begin
            state_q <= ST_EMIT;
          end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= ST_LOW;
            m2_timeout_q <= 1'b1;
            prev_wr_q    <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        ST_EMIT: begin
          if (cap_wr_q && !prev_wr_q) begin
            wr_stb_q <= 1'b1;
            wr_reg_q <= {cap_a14_q, cap_a13_q};
            wr_d0_q  <= cap_d0_q;
            wr_d7_q  <= cap_d7_q;
          end else if (cap_wr_q) begin
            wr_drop_q <= 1'b1;
          end
          prev_wr_q <= cap_wr_q;
          state_q   <= ST_LOW;
        end
        default: begin
          state_q <= ST_LOW;
        end
      endcase
    end
  end

  assign wr_stb_o     = wr_stb_q;
  assign wr_drop_o    = wr_drop_q;
  assign m2_timeout_o = m2_timeout_q;
  assign wr_reg_o     = wr_reg_q;
  assign wr_d0_o      = wr_d0_q;
  assign wr_d7_o      = wr_d7_q;

endmodule

// File: tb/tb_mmc1_cpu_write_filter.sv
// Directed bench for mmc1_cpu_write_filter: a table of whole CPU cycles with
// expected pulse counts and latch values, plus hand sequences for glitches,
// mid-cycle reset and a stuck-high M2.
module tb_mmc1_cpu_write_filter;

  logic       clk;
  logic       rst;
  logic       cpu_m2, ncpu_romsel, ncpu_rw, cpu_a14, cpu_a13, cpu_d7, cpu_d0;
  logic       wr_stb, wr_d0, wr_d7, wr_drop, m2_timeout;
  logic [1:0] wr_reg;

  int  total = 0;
  int  bad   = 0;
  int  n_stb = 0, n_drop = 0, n_to = 0;
  time t_stb = 0, t_to = 0, t_fall = 0, t_rise = 0;

  mmc1_cpu_write_filter #(
    .SYNC_STAGES   (2),
    .GLITCH_CYCLES (2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_m2_i     (cpu_m2),
    .ncpu_romsel_i(ncpu_romsel),
    .ncpu_rw_i    (ncpu_rw),
    .cpu_a14_i    (cpu_a14),
    .cpu_a13_i    (cpu_a13),
    .cpu_d7_i     (cpu_d7),
    .cpu_d0_i     (cpu_d0),
    .wr_stb_o     (wr_stb),
    .wr_reg_o     (wr_reg),
    .wr_d0_o      (wr_d0),
    .wr_d7_o      (wr_d7),
    .wr_drop_o    (wr_drop),
    .m2_timeout_o (m2_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampling on the inactive edge.
  always @(negedge clk) begin
    if (wr_stb)     begin n_stb++;  t_stb = $time; end
    if (wr_drop)    n_drop++;
    if (m2_timeout) begin n_to++;   t_to  = $time; end
  end

  typedef struct {
    logic       wr;     // CPU write
    logic       rom;    // A15=1 (ROMSEL asserted with M2)
    logic [1:0] a;
    logic       d7;
    logic       d0;
    int         e_stb;
    int         e_drop;
    logic [1:0] e_reg;
    logic       e_d7;
    logic       e_d0;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cpu_m2 = 1'b0; ncpu_romsel = 1'b1; ncpu_rw = 1'b1;
  endtask

  // One CPU cycle: hi CLKs of M2 high, then lo CLKs of M2 low.
  task automatic cpu_cycle(input logic wr, input logic rom, input logic [1:0] a,
                           input logic d7, input logic d0, input int hi, input int lo);
    @(negedge clk);
    cpu_m2 = 1'b1; ncpu_romsel = !rom; ncpu_rw = !wr;
    cpu_a14 = a[1]; cpu_a13 = a[0]; cpu_d7 = d7; cpu_d0 = d0;
    t_rise = $time;
    repeat (hi) @(negedge clk);
    idle_bus();
    ncpu_rw = !wr;
    t_fall = $time;
    repeat (lo) @(negedge clk);
    ncpu_rw = 1'b1;
  endtask

  int s_stb, s_drop, s_to;

  task automatic snap();
    s_stb = n_stb; s_drop = n_drop; s_to = n_to;
  endtask

  task automatic check_deltas(input string tag, input int e_stb, input int e_drop, input int e_to);
    check({tag, " stb"},     n_stb  - s_stb,  e_stb);
    check({tag, " drop"},    n_drop - s_drop, e_drop);
    check({tag, " timeout"}, n_to   - s_to,   e_to);
  endtask

  task automatic check_latch(input string tag, input logic [1:0] r, input logic d7, input logic d0);
    check({tag, " reg"}, 32'(wr_reg), 32'(r));
    check({tag, " d7"},  32'(wr_d7),  32'(d7));
    check({tag, " d0"},  32'(wr_d0),  32'(d0));
  endtask

  initial begin
    // wr rom a d7 d0 | stb drop reg d7 d0
    vecs[0] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1, 0, 2'b11, 1'b0, 1'b1}; // single write
    vecs[1] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 0, 1, 2'b11, 1'b0, 1'b1}; // RMW second write
    vecs[2] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 2'b11, 1'b0, 1'b1}; // ROM read
    vecs[3] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1, 0, 2'b10, 1'b0, 1'b0}; // separated write
    vecs[4] = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 0, 0, 2'b10, 1'b0, 1'b0}; // RAM write
    vecs[5] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1, 0, 2'b01, 1'b1, 1'b0}; // reset write
    vecs[6] = '{1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 0, 1, 2'b01, 1'b1, 1'b0}; // consecutive D7 write
    vecs[7] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 0, 1, 2'b01, 1'b1, 1'b0}; // third in a row
    vecs[8] = '{1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 0, 0, 2'b01, 1'b1, 1'b0}; // ROM read
    vecs[9] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1, 0, 2'b11, 1'b0, 1'b0}; // write after read

    rst = 1'b1;
    idle_bus();
    cpu_a14 = 1'b0; cpu_a13 = 1'b0; cpu_d7 = 1'b0; cpu_d0 = 1'b0;
    repeat (3) @(negedge clk);
    settle();
    check("reset stb",     32'(wr_stb),     0);
    check("reset drop",    32'(wr_drop),    0);
    check("reset timeout", 32'(m2_timeout), 0);
    check_latch("reset", 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table of whole CPU cycles, M2 high 6 CLK / low 8 CLK.
    for (int i = 0; i < 10; i++) begin
      settle();
      snap();
      cpu_cycle(vecs[i].wr, vecs[i].rom, vecs[i].a, vecs[i].d7, vecs[i].d0, 6, 8);
      settle();
      check_deltas($sformatf("v%0d", i), vecs[i].e_stb, vecs[i].e_drop, 0);
      check_latch($sformatf("v%0d", i), vecs[i].e_reg, vecs[i].e_d7, vecs[i].e_d0);
      // Fall driven half a CLK before edge k; strobe seen at negedge after edge k+5.
      if (vecs[i].e_stb == 1)
        check($sformatf("v%0d latency", i), 32'(t_stb - t_fall), 60);
    end

    // Single write with a 12-CLK M2 period after a read clears the RMW history.
    cpu_cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 6, 8);
    settle();
    snap();
    cpu_cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 6, 6);
    repeat (4) @(negedge clk);
    settle();
    check_deltas("p12", 1, 0, 0);
    check("p12 latency", 32'(t_stb - t_fall), 60);
    check_latch("p12", 2'b11, 1'b0, 1'b1);

    // 1-CLK M2 high pulse with write conditions: ignored.
    snap();
    @(negedge clk);
    cpu_m2 = 1'b1; ncpu_romsel = 1'b0; ncpu_rw = 1'b0; cpu_d0 = 1'b0;
    @(negedge clk);
    idle_bus();
    repeat (12) @(negedge clk);
    settle();
    check_deltas("hi glitch", 0, 0, 0);
    check_latch("hi glitch", 2'b11, 1'b0, 1'b1);

    // Glitch is not a completed cycle: previous write still counts, so drop.
    snap();
    cpu_cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 6, 8);
    settle();
    check_deltas("after glitch", 0, 1, 0);

    // 1-CLK low glitch inside a write high phase: one cycle, one strobe.
    cpu_cycle(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 6, 8);
    settle();
    snap();
    @(negedge clk);
    cpu_m2 = 1'b1; ncpu_romsel = 1'b0; ncpu_rw = 1'b0;
    cpu_a14 = 1'b1; cpu_a13 = 1'b0; cpu_d7 = 1'b0; cpu_d0 = 1'b1;
    repeat (3) @(negedge clk);
    cpu_m2 = 1'b0; ncpu_romsel = 1'b1;
    @(negedge clk);
    cpu_m2 = 1'b1; ncpu_romsel = 1'b0;
    repeat (3) @(negedge clk);
    idle_bus();
    t_fall = $time;
    repeat (8) @(negedge clk);
    settle();
    check_deltas("lo glitch", 1, 0, 0);
    check("lo glitch latency", 32'(t_stb - t_fall), 60);
    check_latch("lo glitch", 2'b10, 1'b0, 1'b1);

    // Reset in the middle of a write high phase.
    snap();
    @(negedge clk);
    cpu_m2 = 1'b1; ncpu_romsel = 1'b0; ncpu_rw = 1'b0;
    cpu_a14 = 1'b0; cpu_a13 = 1'b1; cpu_d0 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    settle();
    check("midrst stb",     32'(wr_stb),     0);
    check("midrst drop",    32'(wr_drop),    0);
    check("midrst timeout", 32'(m2_timeout), 0);
    check_latch("midrst", 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    idle_bus();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    settle();
    check_deltas("midrst abandon", 0, 0, 0);
    // Reset cleared the previous-write history, so this is accepted.
    snap();
    cpu_cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 6, 8);
    settle();
    check_deltas("post rst", 1, 0, 0);
    check_latch("post rst", 2'b11, 1'b0, 1'b1);

    // M2 stuck high 100 CLK with write conditions, right after a mapper write.
    snap();
    cpu_cycle(1'b1, 1'b1, 2'b01, 1'b0, 1'b1, 100, 8);
    settle();
    check_deltas("stuck", 0, 0, 1);
    // Rise at t_rise; filtered high 3.5 CLK later; HIGH counts 0..63 then fires.
    check("stuck timeout time", 32'(t_to - t_rise), 690);
    check_latch("stuck", 2'b11, 1'b0, 1'b1);
    snap();
    cpu_cycle(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 6, 8);
    settle();
    check_deltas("after stuck", 1, 0, 0);
    check_latch("after stuck", 2'b00, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
